axil_counter_regs: RTL and testbench
====================================

# axil_counter_regs

AXI4-Lite slave register block for the counter IP, the stage directly downstream of the AXI master VIP/processor port. Decodes AXI4-Lite read/write transactions into four 32-bit registers and drives an embedded programmable up/down counter whose live value and rollover status are readable over the same bus. Counter value and rollover pulse are also exported to fabric.

## Interface
- C_S_AXI_DATA_WIDTH, 32, bus data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select register, [1:0] ignored.
- s00_axi_aclk  in  1  sole clock; all logic rising-edge.
- s00_axi_aresetn  in  1  asynchronous, active-low reset; release synchronised externally to aclk.
- s00_axi_awaddr  in  4  write address. s00_axi_awprot in 3, ignored.
- s00_axi_awvalid / s00_axi_awready  in / out  1  write-address handshake.
- s00_axi_wdata  in  32; s00_axi_wstrb  in  4 byte enables.
- s00_axi_wvalid / s00_axi_wready  in / out  1  write-data handshake.
- s00_axi_bresp  out  2  always 2'b00 (OKAY); s00_axi_bvalid out 1, s00_axi_bready in 1.
- s00_axi_araddr  in  4; s00_axi_arprot in 3, ignored; s00_axi_arvalid in 1, s00_axi_arready out 1.
- s00_axi_rdata  out  32; s00_axi_rresp  out  2  always OKAY; s00_axi_rvalid out 1, s00_axi_rready in 1.
- count_out  out  32  live counter value.
- roll_pulse  out  1  one-cycle pulse on each rollover.

## Operation
- Register map: 0x0 CTRL RW (bit0 EN, bit1 DIR 0=up 1=down, bit2 CLR self-clearing, reads 0; bits[31:3] read 0). 0x4 LIMIT RW. 0x8 COUNT RO (writes accepted with OKAY, ignored). 0xC STATUS bit0 ROLL sticky, write-1-to-clear via wstrb[0].
- CTRL/LIMIT writes honour wstrb per byte.
- Write FSM W_IDLE -> W_RESP: in W_IDLE, awready and wready asserted together for exactly one cycle only when awvalid && wvalid; register updated on that edge; next state W_RESP with bvalid=1 held until bready, then W_IDLE. Lone awvalid or wvalid is left waiting.
- Read FSM R_IDLE -> R_DATA: arready=1 in R_IDLE; on arvalid handshake rdata latched from addressed register, rvalid=1 held (rdata stable) until rready, then R_IDLE.
- Read and write channels independent; may complete in same cycle.
- Counter, when EN=1: up — count==LIMIT -> 0 and roll, else +1; down — count==0 -> LIMIT and roll, else -1. Modulo-2^32 arithmetic; LIMIT=0 means roll every enabled cycle at 0.
- roll: roll_pulse high one cycle, STATUS.ROLL set.
- Precedence: CLR beats EN (count->0, no roll). Sticky set beats same-cycle W1C. LIMIT write below current count (up): count continues to wrap at 2^32-1 -> 0 without roll until it hits LIMIT.

## Timing
- Reset (async assert): awready, wready, bvalid, arready, rvalid, roll_pulse=0; rdata=0; bresp/rresp=0; CTRL=0, LIMIT=32'hFFFF_FFFF, count=0, ROLL=0; FSMs to IDLE. arready rises first cycle after release.
- Reset mid-transaction drops bvalid/rvalid immediately; pending response lost.
- Write latency: handshake cycle N, bvalid at N+1; register value visible to counter from N+1.
- Read latency: ar handshake cycle N, rvalid/rdata at N+1. Read of COUNT returns value at edge N.
- Max throughput: one write per 2 cycles with bready tied high; same for reads.

## Structure
- Package axil_counter_pkg: register offsets, CTRL/STATUS bit indices, RESP_OKAY, write/read state enums, LIMIT reset constant.
- Sub-module counter_core: count, LIMIT/EN/DIR/CLR in, count_out and roll_pulse out; top holds AXI FSMs and register file.

## Test plan
- Reset then read all four offsets -> 0x0, 0xFFFFFFFF, 0x0, 0x0, rresp OKAY.
- Write LIMIT=3, CTRL=0x1, wait 10 cycles -> COUNT cycles 0,1,2,3,0…; roll_pulse every 4th cycle; STATUS=1; write STATUS=1 -> reads 0.
- CTRL=0x3 (down) with LIMIT=5 from count 0 -> next count 5, roll_pulse=1.
- awvalid 3 cycles before wvalid, bready low 4 cycles -> single handshake cycle, bvalid held until bready, single register update.
- Write LIMIT with wstrb=4'b0010, data 0x0000AB00 on LIMIT=0xFFFFFFFF -> 0xFFFFABFF; write COUNT -> ignored, bresp OKAY.
- Assert aresetn low while rvalid high -> rvalid 0 same cycle, all registers at reset values.

Source files
------------

// File: rtl/axil_counter_pkg.sv
// rtl/axil_counter_pkg.sv - shared constants and types for the counter register block
package axil_counter_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LIMIT  = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_DIR_BIT    = 1;
  localparam int CTRL_CLR_BIT    = 2;
  localparam int STATUS_ROLL_BIT = 0;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [31:0] LIMIT_RESET = 32'hFFFF_FFFF;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/counter_core.sv
// rtl/counter_core.sv - programmable up/down counter with rollover at LIMIT (up) or 0 (down)
module counter_core
  import axil_counter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        dir,
  input  logic        clr,
  input  logic [31:0] limit,
  output logic [31:0] count,
  output logic        roll_event,
  output logic        roll_pulse
);

  logic [31:0] count_next;

  // Up counting never rolls past 2^32-1; only an exact LIMIT match rolls.
  always_comb begin
    count_next = count;
    roll_event = 1'b0;
    if (clr) begin
      count_next = 32'd0;
    end else if (en) begin
      if (!dir) begin
        if (count == limit) begin
          count_next = 32'd0;
          roll_event = 1'b1;
        end else begin
          count_next = count + 32'd1;
        end
      end else begin
        if (count == 32'd0) begin
          count_next = limit;
          roll_event = 1'b1;
        end else begin
          count_next = count - 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 32'd0;
      roll_pulse <= 1'b0;
    end else begin
      count      <= count_next;
      roll_pulse <= roll_event;
    end
  end

endmodule

// File: rtl/axil_counter_regs.sv
// rtl/axil_counter_regs.sv - AXI4-Lite register block driving the embedded counter core
module axil_counter_regs
  import axil_counter_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [31:0]                     count_out,
  output logic                            roll_pulse
);

  logic clk;
  logic rst_n;
  assign clk   = s00_axi_aclk;
  assign rst_n = s00_axi_aresetn;

  w_state_t w_state, w_state_next;
  r_state_t r_state, r_state_next;
  logic     wr_en;
  logic     rd_en;

  logic        ctrl_en;
  logic        ctrl_dir;
  logic        clr_pulse;
  logic [31:0] limit;
  logic        roll_sticky;
  logic        roll_event;
  logic [31:0] read_mux;
  logic [1:0]  wr_sel;
  logic [1:0]  rd_sel;

  assign wr_sel = s00_axi_awaddr[3:2];
  assign rd_sel = s00_axi_araddr[3:2];

  logic unused_ok;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign s00_axi_bresp = RESP_OKAY;
  assign s00_axi_rresp = RESP_OKAY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_state_next;
  end

  // Address and data are only taken together, so a lone valid just waits.
  always_comb begin
    w_state_next    = w_state;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    wr_en           = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (rst_n && s00_axi_awvalid && s00_axi_wvalid) begin
          s00_axi_awready = 1'b1;
          s00_axi_wready  = 1'b1;
          wr_en           = 1'b1;
          w_state_next    = W_RESP;
        end
      end
      W_RESP: begin
        s00_axi_bvalid = 1'b1;
        if (s00_axi_bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_state_next;
  end

  always_comb begin
    r_state_next    = r_state;
    s00_axi_arready = 1'b0;
    s00_axi_rvalid  = 1'b0;
    rd_en           = 1'b0;
    case (r_state)
      R_IDLE: begin
        s00_axi_arready = rst_n;
        if (rst_n && s00_axi_arvalid) begin
          rd_en        = 1'b1;
          r_state_next = R_DATA;
        end
      end
      R_DATA: begin
        s00_axi_rvalid = 1'b1;
        if (s00_axi_rready) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    read_mux = 32'd0;
    case (rd_sel)
      REG_CTRL:  read_mux = {30'd0, ctrl_dir, ctrl_en};
      REG_LIMIT: read_mux = limit;
      REG_COUNT: read_mux = count_out;
      default:   read_mux = {31'd0, roll_sticky};
    endcase
  end

  // CLR is a one-cycle pulse so it never reads back and cannot stick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en       <= 1'b0;
      ctrl_dir      <= 1'b0;
      clr_pulse     <= 1'b0;
      limit         <= LIMIT_RESET;
      roll_sticky   <= 1'b0;
      s00_axi_rdata <= '0;
    end else begin
      clr_pulse <= 1'b0;
      if (wr_en) begin
        case (wr_sel)
          REG_CTRL: begin
            if (s00_axi_wstrb[0]) begin
              ctrl_en   <= s00_axi_wdata[CTRL_EN_BIT];
              ctrl_dir  <= s00_axi_wdata[CTRL_DIR_BIT];
              clr_pulse <= s00_axi_wdata[CTRL_CLR_BIT];
            end
          end
          REG_LIMIT: limit <= merge_bytes(limit, s00_axi_wdata, s00_axi_wstrb);
          default: ;
        endcase
      end
      if (roll_event) begin
        roll_sticky <= 1'b1;
      end else if (wr_en && wr_sel == REG_STATUS && s00_axi_wstrb[0] &&
                   s00_axi_wdata[STATUS_ROLL_BIT]) begin
        roll_sticky <= 1'b0;
      end
      if (rd_en) s00_axi_rdata <= read_mux;
    end
  end

  counter_core u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (ctrl_en),
    .dir        (ctrl_dir),
    .clr        (clr_pulse),
    .limit      (limit),
    .count      (count_out),
    .roll_event (roll_event),
    .roll_pulse (roll_pulse)
  );

endmodule

// File: tb/tb_axil_counter_regs.sv
// tb/tb_axil_counter_regs.sv - self-checking bench for axil_counter_regs
module tb_axil_counter_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] count_out;
  logic        roll_pulse;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  axil_counter_regs dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .count_out       (count_out),
    .roll_pulse      (roll_pulse)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bus-visible state of the block, advanced once per clock.
  logic        m_en, m_dir, m_clr, m_roll, m_sticky, m_bvalid, m_rvalid;
  logic [31:0] m_count, m_limit, m_rdata;
  logic        mw_hs, mr_hs, m_rl, m_ctrl_wr, m_stat_clr;
  logic [31:0] m_nc, m_rv, m_mask, m_lim_next;

  always_comb begin
    mw_hs      = awvalid && wvalid && !m_bvalid;
    mr_hs      = arvalid && !m_rvalid;
    m_mask     = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    m_lim_next = (mw_hs && awaddr[3:2] == 2'd1) ? ((m_limit & ~m_mask) | (wdata & m_mask)) : m_limit;
    m_ctrl_wr  = mw_hs && awaddr[3:2] == 2'd0 && wstrb[0];
    m_stat_clr = mw_hs && awaddr[3:2] == 2'd3 && wstrb[0] && wdata[0];
    m_rl = 1'b0;
    m_nc = m_count;
    if (m_clr) m_nc = 32'd0;
    else if (m_en && !m_dir) begin
      m_rl = (m_count == m_limit);
      m_nc = m_rl ? 32'd0 : m_count + 32'd1;
    end else if (m_en) begin
      m_rl = (m_count == 32'd0);
      m_nc = m_rl ? m_limit : m_count - 32'd1;
    end
    case (araddr[3:2])
      2'd0:    m_rv = {30'd0, m_dir, m_en};
      2'd1:    m_rv = m_limit;
      2'd2:    m_rv = m_count;
      default: m_rv = {31'd0, m_sticky};
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en <= 1'b0; m_dir <= 1'b0; m_clr <= 1'b0; m_roll <= 1'b0; m_sticky <= 1'b0;
      m_bvalid <= 1'b0; m_rvalid <= 1'b0;
      m_count <= 32'd0; m_limit <= 32'hFFFF_FFFF; m_rdata <= 32'd0;
    end else begin
      m_count  <= m_nc;
      m_roll   <= m_rl;
      m_limit  <= m_lim_next;
      if (m_ctrl_wr) begin
        m_en  <= wdata[0];
        m_dir <= wdata[1];
      end
      m_clr    <= m_ctrl_wr && wdata[2];
      m_sticky <= m_rl ? 1'b1 : (m_stat_clr ? 1'b0 : m_sticky);
      m_bvalid <= mw_hs || (m_bvalid && !bready);
      m_rvalid <= mr_hs || (m_rvalid && !rready);
      if (mr_hs) m_rdata <= m_rv;
    end
  end

  task automatic monitor_step();
    chk("awready", awready, rst_n && !m_bvalid && awvalid && wvalid);
    chk("wready", wready, rst_n && !m_bvalid && awvalid && wvalid);
    chk("bvalid", bvalid, m_bvalid);
    chk("bresp", bresp, 2'b00);
    chk("arready", arready, rst_n && !m_rvalid);
    chk("rvalid", rvalid, m_rvalid);
    chk("rdata", rdata, m_rdata);
    chk("rresp", rresp, 2'b00);
    chk("count_out", count_out, m_count);
    chk("roll_pulse", roll_pulse, m_roll);
    if (awvalid && wvalid && awready && wready) hs_cnt++;
  endtask

  always @(negedge clk) monitor_step();

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_lead, input int b_delay, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s;
    repeat (aw_lead) begin @(posedge clk); #1; end
    wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(awready === 1'b1 && wready === 1'b1) && n < 50);
    chk("write_handshake_timeout", n < 50, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (b_delay) begin @(posedge clk); #1; end
    bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (bvalid !== 1'b1 && n < 50);
    chk("bvalid_timeout", n < 50, 1'b1);
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (arready !== 1'b1 && n < 50);
    chk("read_handshake_timeout", n < 50, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (rvalid !== 1'b1 && n < 50);
    chk("rvalid_timeout", n < 50, 1'b1);
    d = rdata; resp = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d2;
    logic [1:0]  r, r2;
    int          h0, n;
    int          up_seq[10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    axi_read(4'h0, d, r); chk("rst_ctrl", d, 32'h0); chk("rst_rresp", r, 2'b00);
    axi_read(4'h4, d, r); chk("rst_limit", d, 32'hFFFF_FFFF);
    axi_read(4'h8, d, r); chk("rst_count", d, 32'h0);
    axi_read(4'hC, d, r); chk("rst_status", d, 32'h0);

    // Up count modulo LIMIT+1
    axi_write(4'h4, 32'd3, 4'hF, 0, 0, r);
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, r);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("up_seq", count_out, up_seq[i]);
      chk("up_roll", roll_pulse, up_seq[i] == 0);
    end
    axi_write(4'h0, 32'h0, 4'hF, 0, 0, r);
    axi_read(4'hC, d, r); chk("status_sticky", d, 32'h1);
    axi_write(4'hC, 32'h1, 4'hF, 0, 0, r);
    axi_read(4'hC, d, r); chk("status_w1c", d, 32'h0);

    // Down count from 0 reloads LIMIT and rolls
    axi_write(4'h0, 32'h4, 4'hF, 0, 0, r);
    axi_read(4'h8, d, r); chk("clr_count", d, 32'h0);
    axi_read(4'h0, d, r); chk("clr_reads_zero", d, 32'h0);
    axi_write(4'h4, 32'd5, 4'hF, 0, 0, r);
    axi_write(4'h0, 32'h3, 4'hF, 0, 0, r);
    @(negedge clk); chk("down_reload", count_out, 32'd5); chk("down_roll", roll_pulse, 1'b1);
    @(negedge clk); chk("down_dec", count_out, 32'd4); chk("down_noroll", roll_pulse, 1'b0);
    axi_write(4'h0, 32'h4, 4'hF, 0, 0, r);

    // Skewed valids and stalled bready give one handshake
    h0 = hs_cnt;
    axi_write(4'h4, 32'h1234_5678, 4'hF, 3, 4, r);
    chk("single_handshake", hs_cnt - h0, 32'd1);
    chk("skew_bresp", r, 2'b00);
    axi_read(4'h4, d, r); chk("skew_limit", d, 32'h1234_5678);

    // LIMIT=0 rolls every enabled cycle; roll beats a same-cycle W1C
    axi_write(4'h4, 32'd0, 4'hF, 0, 0, r);
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, r);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lim0_count", count_out, 32'd0);
      chk("lim0_roll", roll_pulse, 1'b1);
    end
    axi_write(4'hC, 32'h1, 4'h1, 0, 0, r);
    axi_read(4'hC, d, r); chk("sticky_beats_w1c", d, 32'h1);
    axi_write(4'h0, 32'h4, 4'hF, 0, 0, r);

    // Byte strobes and read-only COUNT
    axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
    axi_write(4'h4, 32'h0000_AB00, 4'b0010, 0, 0, r);
    axi_read(4'h4, d, r); chk("wstrb_limit", d, 32'hFFFF_ABFF);
    axi_write(4'h8, 32'hDEAD_BEEF, 4'hF, 0, 0, r); chk("count_wr_bresp", r, 2'b00);
    axi_read(4'h8, d, r); chk("count_wr_ignored", d, 32'h0);

    fork
      axi_write(4'h0, 32'h0, 4'hF, 0, 0, r2);
      axi_read(4'h4, d2, r);
    join
    chk("concurrent_read", d2, 32'hFFFF_ABFF);
    chk("concurrent_bresp", r2, 2'b00);

    // Reset while a read response is pending
    @(posedge clk); #1;
    araddr = 4'h4; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (arready !== 1'b1 && n < 50);
    chk("pre_reset_ar_timeout", n < 50, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid_before_reset", rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rvalid_async_drop", rvalid, 1'b0);
    chk("arready_in_reset", arready, 1'b0);
    chk("count_in_reset", count_out, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    axi_read(4'h0, d, r); chk("rst2_ctrl", d, 32'h0);
    axi_read(4'h4, d, r); chk("rst2_limit", d, 32'hFFFF_FFFF);
    axi_read(4'h8, d, r); chk("rst2_count", d, 32'h0);
    axi_read(4'hC, d, r); chk("rst2_status", d, 32'h0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
